// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_sub_1.sv
// One-bit full subtractor: d = ai - bi - br, bo is the borrow out.
module full_sub_1 (
    input  logic ai,
    input  logic bi,
    input  logic br,
    output logic d,
    output logic bo
);

    assign d  = ai ^ bi ^ br;
    assign bo = (~ai & bi) | (~(ai ^ bi) & br);

endmodule

// File: rtl/serial_sub_4.sv
// Bit-serial subtractor, LSB first, start/busy/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub_4
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic fs_diff;
    logic fs_bout;

    full_sub_1 u_full_sub (
        .ai (a_q[0]),
        .bi (b_q[0]),
        .br (br_q),
        .d  (fs_diff),
        .bo (fs_bout)
    );

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept aside since the operand registers shift away.
    logic sa_q, sa_d;
    logic sb_q, sb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d    = a[WIDTH-1];
                    sb_d    = b[WIDTH-1];
`endif
                end
            end
            StRun: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = fs_diff;
                br_d             = fs_bout;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    diff_d  = res_d;
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // The final serial bit is the sign bit of the difference.
                    ovf_d   = (sa_q ^ sb_q) & (fs_diff ^ sa_q);
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_4.sv
// Directed self-checking bench for serial_sub_4 (WIDTH=4).
module tb_serial_sub_4;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs and samples both change #1 after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic binv, input logic [W-1:0] exp_diff,
                          input logic exp_bout);
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " no done"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(exp_diff));
        check({tag, " bout"}, 32'(bout), 32'(exp_bout));
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int           r;
        logic [4:0]   e;
        int           dones;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);

        run_op("basic 9-5", 4'd9, 4'd5, 1'b0, 4'd4, 1'b0);
        run_op("chain 2-5-1", 4'd2, 4'd5, 1'b1, 4'd12, 1'b1);
        run_op("chain 0-0-1", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);
        run_op("chain 15-15", 4'd15, 4'd15, 1'b0, 4'd0, 1'b0);

        // Start held for 10 edges; inputs scrambled while running.
        a     = 4'd6;
        b     = 4'd5;
        bin   = 1'b0;
        start = 1'b1;
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            check($sformatf("held start done c%0d", c), 32'(done),
                  32'((c == 5) || (c == 11)));
            if (done) begin
                dones++;
                check($sformatf("held start diff c%0d", c), 32'(diff), 32'd1);
                check($sformatf("held start bout c%0d", c), 32'(bout), 32'd0);
            end
            if (c == 1) begin
                a   = 4'd0;
                b   = 4'd15;
                bin = 1'b1;
            end
            if (c == 5) begin
                a   = 4'd6;
                b   = 4'd5;
                bin = 1'b0;
            end
            if (c == 7) begin
                a   = 4'd3;
                b   = 4'd9;
                bin = 1'b1;
            end
            if (c == 10) start = 1'b0;
        end
        check("held start done count", 32'(dones), 32'd2);

        // Reset during the second RUN cycle aborts the operation.
        a     = 4'd12;
        b     = 4'd3;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort bout", 32'(bout), 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) dones++;
        end
        check("abort no done", 32'(dones), 32'd0);
        run_op("after abort 12-3", 4'd12, 4'd3, 1'b0, 4'd9, 1'b0);

        // Reset beats a simultaneous start.
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        check("rst wins busy", 32'(busy), 32'd0);
        tick();
        check("rst wins idle", 32'(busy), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
        run_op("ovf 8-1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
        check("ovf 8-1 ovf", 32'(ovf), 32'd1);
        run_op("ovf 3-2", 4'd3, 4'd2, 1'b0, 4'd1, 1'b0);
        check("ovf 3-2 ovf", 32'(ovf), 32'd0);
`endif

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    r = ai - bi - ci;
                    e = r[4:0];
                    run_op($sformatf("sweep %0d-%0d-%0d", ai, bi, ci), 4'(ai), 4'(bi),
                           1'(ci), e[3:0], e[4]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
